// File: rtl/npu_fifo_controller_if.sv
// Bundle of EX request, NPU input/result and status signals for the NPU FIFO controller.
// Latency: none (wires only).
// Backpressure: carries the stall, npu_valid/npu_ready and resp_valid/resp_ready handshakes.
interface npu_fifo_controller_if #(
  parameter int AW = 3
);
  logic          cfg_we;
  logic [31:0]   cfg_data;
  logic          enq_we;
  logic [31:0]   enq_data;
  logic          deq_re;
  logic [31:0]   deq_data;
  logic          stall;
  logic          npu_valid;
  logic [31:0]   npu_data;
  logic          npu_is_cfg;
  logic          npu_ready;
  logic          npu_resp_valid;
  logic [31:0]   npu_resp_data;
  logic          npu_resp_ready;
  logic [AW:0]   cfg_count;
  logic [AW:0]   enq_count;
  logic [AW:0]   deq_count;
  logic          busy;

  // Controller side.
  modport slave (
    input  cfg_we, cfg_data, enq_we, enq_data, deq_re,
    input  npu_ready, npu_resp_valid, npu_resp_data,
    output deq_data, stall, npu_valid, npu_data, npu_is_cfg,
    output npu_resp_ready, cfg_count, enq_count, deq_count, busy
  );

  // EX stage / NPU side.
  modport master (
    output cfg_we, cfg_data, enq_we, enq_data, deq_re,
    output npu_ready, npu_resp_valid, npu_resp_data,
    input  deq_data, stall, npu_valid, npu_data, npu_is_cfg,
    input  npu_resp_ready, cfg_count, enq_count, deq_count, busy
  );
endinterface

// File: rtl/npu_fifo_controller.sv
// Buffers EX config/enqueue words onto the NPU input bus (config first) and NPU results for dequeue.
// Latency: 2 cycles from an enqueue into an empty FIFO to npu_valid; dequeue data is combinational.
// Backpressure: stall when a requested FIFO is full/empty (registered state); npu_ready holds the output word.
module npu_fifo_controller #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic iClk,
  input  logic iRst_n,
  npu_fifo_controller_if.slave bus
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND_CFG  = 2'd1;
  localparam logic [1:0] ST_SEND_DATA = 2'd2;

  logic [31:0] cfg_mem [DEPTH];
  logic [31:0] enq_mem [DEPTH];
  logic [31:0] res_mem [DEPTH];

  logic [AW:0] cfg_wr, cfg_rd;
  logic [AW:0] enq_wr, enq_rd;
  logic [AW:0] res_wr, res_rd;

  logic [1:0]  state;
  logic        npu_valid_q;
  logic [31:0] npu_data_q;
  logic        npu_is_cfg_q;

  logic cfg_full, cfg_empty;
  logic enq_full, enq_empty;
  logic res_full, res_empty;
  logic stall;
  logic cfg_push, enq_push, res_push, res_pop;
  logic load, cfg_pop, enq_pop;

  // Full: same slot index, different lap bit. Empty: pointers identical.
  assign cfg_full  = (cfg_wr[AW] != cfg_rd[AW]) && (cfg_wr[AW-1:0] == cfg_rd[AW-1:0]);
  assign enq_full  = (enq_wr[AW] != enq_rd[AW]) && (enq_wr[AW-1:0] == enq_rd[AW-1:0]);
  assign res_full  = (res_wr[AW] != res_rd[AW]) && (res_wr[AW-1:0] == res_rd[AW-1:0]);
  assign cfg_empty = (cfg_wr == cfg_rd);
  assign enq_empty = (enq_wr == enq_rd);
  assign res_empty = (res_wr == res_rd);

  // Any one blocked EX request freezes all EX requests this cycle; a same-cycle
  // FSM pop does not relieve a full FIFO because the flags are registered state.
  assign stall    = (bus.cfg_we & cfg_full) | (bus.enq_we & enq_full) | (bus.deq_re & res_empty);
  assign cfg_push = bus.cfg_we & ~stall;
  assign enq_push = bus.enq_we & ~stall;
  assign res_pop  = bus.deq_re & ~stall;
  assign res_push = bus.npu_resp_valid & ~res_full;

  // Output register reloads when idle or on a handshake; config wins over data.
  assign load    = (state == ST_IDLE) | (npu_valid_q & bus.npu_ready);
  assign cfg_pop = load & ~cfg_empty;
  assign enq_pop = load & cfg_empty & ~enq_empty;

  assign bus.stall          = stall;
  assign bus.deq_data       = res_mem[res_rd[AW-1:0]];
  assign bus.npu_valid      = npu_valid_q;
  assign bus.npu_data       = npu_data_q;
  assign bus.npu_is_cfg     = npu_is_cfg_q;
  assign bus.npu_resp_ready = ~res_full;
  assign bus.cfg_count      = cfg_wr - cfg_rd;
  assign bus.enq_count      = enq_wr - enq_rd;
  assign bus.deq_count      = res_wr - res_rd;
  assign bus.busy           = ~cfg_empty | ~enq_empty | ~res_empty | npu_valid_q;

  // FIFO storage writes; contents are deliberately left unreset.
  always_ff @(posedge iClk) begin
    if (cfg_push) cfg_mem[cfg_wr[AW-1:0]] <= bus.cfg_data;
    if (enq_push) enq_mem[enq_wr[AW-1:0]] <= bus.enq_data;
    if (res_push) res_mem[res_wr[AW-1:0]] <= bus.npu_resp_data;
  end

  // Pointer updates; a push and a pop on the same FIFO in one cycle leave the count unchanged.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      cfg_wr <= '0;
      cfg_rd <= '0;
      enq_wr <= '0;
      enq_rd <= '0;
      res_wr <= '0;
      res_rd <= '0;
    end else begin
      if (cfg_push) cfg_wr <= cfg_wr + 1'b1;
      if (cfg_pop)  cfg_rd <= cfg_rd + 1'b1;
      if (enq_push) enq_wr <= enq_wr + 1'b1;
      if (enq_pop)  enq_rd <= enq_rd + 1'b1;
      if (res_push) res_wr <= res_wr + 1'b1;
      if (res_pop)  res_rd <= res_rd + 1'b1;
    end
  end

  // NPU output FSM: load the next head on idle or handshake, otherwise hold the word stable.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state        <= ST_IDLE;
      npu_valid_q  <= 1'b0;
      npu_data_q   <= '0;
      npu_is_cfg_q <= 1'b0;
    end else if (load) begin
      if (cfg_pop) begin
        state        <= ST_SEND_CFG;
        npu_valid_q  <= 1'b1;
        npu_data_q   <= cfg_mem[cfg_rd[AW-1:0]];
        npu_is_cfg_q <= 1'b1;
      end else if (enq_pop) begin
        state        <= ST_SEND_DATA;
        npu_valid_q  <= 1'b1;
        npu_data_q   <= enq_mem[enq_rd[AW-1:0]];
        npu_is_cfg_q <= 1'b0;
      end else begin
        state        <= ST_IDLE;
        npu_valid_q  <= 1'b0;
      end
    end
  end

endmodule
